id_decode_queue: RTL and testbench

- Decode-stage successor: accepts fetched MIPS instructions over a valid/ready handshake and decodes each one into the operation, register-read, write-back and immediate fields.
- Decoded entries are held in a DEPTH-deep FIFO and issued in order to execute over a second valid/ready handshake.
- Supports branch flush with optional delay-slot retention, and flags reserved instructions.
- Sits between the IF stage and the EX stage.

---
 rtl/id_decode_queue_pkg.sv | 94 +++++++++
 rtl/id_decode_queue_inst_decode.sv | 136 +++++++++++++
 rtl/id_decode_queue.sv | 113 +++++++++++
 tb/tb_id_decode_queue.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_decode_queue_pkg.sv
// Shared decode-stage types: operations, opcode fields, queue entry.
// Also holds the per-instruction operand form table used by the decoder.
package id_decode_queue_pkg;

    typedef logic [31:0] Inst_t;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [5:0] {
        OP_NOP, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
        OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_SLT, OP_SLTU,
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
        OP_MUL, OP_MULT, OP_MULTU, OP_CLZ, OP_CLO,
        OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
        OP_J, OP_JAL, OP_JR, OP_JALR,
        OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ,
        OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL,
        OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
        OP_SB, OP_SH, OP_SW
    } Oper_t;

    localparam logic [5:0] OPC_SPECIAL  = 6'h00, OPC_REGIMM = 6'h01;
    localparam logic [5:0] OPC_J        = 6'h02, OPC_JAL    = 6'h03;
    localparam logic [5:0] OPC_BEQ      = 6'h04, OPC_BNE    = 6'h05;
    localparam logic [5:0] OPC_BLEZ     = 6'h06, OPC_BGTZ   = 6'h07;
    localparam logic [5:0] OPC_ADDI     = 6'h08, OPC_ADDIU  = 6'h09;
    localparam logic [5:0] OPC_SLTI     = 6'h0a, OPC_SLTIU  = 6'h0b;
    localparam logic [5:0] OPC_ANDI     = 6'h0c, OPC_ORI    = 6'h0d;
    localparam logic [5:0] OPC_XORI     = 6'h0e, OPC_LUI    = 6'h0f;
    localparam logic [5:0] OPC_SPECIAL2 = 6'h1c;
    localparam logic [5:0] OPC_LB = 6'h20, OPC_LH = 6'h21, OPC_LW = 6'h23;
    localparam logic [5:0] OPC_LBU = 6'h24, OPC_LHU = 6'h25;
    localparam logic [5:0] OPC_SB = 6'h28, OPC_SH = 6'h29, OPC_SW = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08, FN_JALR = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI = 6'h11;
    localparam logic [5:0] FN_MFLO = 6'h12, FN_MTLO = 6'h13;
    localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22, FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26, FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a, FN_SLTU = 6'h2b;
    localparam logic [5:0] FN2_MUL = 6'h02, FN2_CLZ = 6'h20, FN2_CLO = 6'h21;
    localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;

    typedef struct packed {
        Oper_t       oper;
        logic        reg1_read;
        logic [4:0]  reg1_addr;
        logic        reg2_read;
        logic [4:0]  reg2_addr;
        logic        wreg_write;
        logic [4:0]  wreg_addr;
        logic [31:0] immediate;
        logic [31:0] pc;
        logic        rsvd;
    } Id_entry_t;

    typedef enum logic [1:0] {W_NONE, W_RT, W_RD, W_RA} Wsel_t;
    typedef enum logic [2:0] {I_ZERO, I_ZEXT, I_SEXT, I_SA, I_JIDX} Isel_t;

    // Operand form: which registers are read, where the result goes,
    // and how the immediate is built.
    typedef struct packed {
        logic  rd_rs;
        logic  rd_rt;
        Wsel_t wsel;
        Isel_t isel;
        logic  rsvd;
    } Form_t;

    localparam Form_t FM_RSVD = '{1'b0, 1'b0, W_NONE, I_ZERO, 1'b1};
    localparam Form_t FM_LOGI = '{1'b1, 1'b0, W_RT,   I_ZEXT, 1'b0};
    localparam Form_t FM_ARI  = '{1'b1, 1'b0, W_RT,   I_SEXT, 1'b0};
    localparam Form_t FM_LUI  = '{1'b0, 1'b0, W_RT,   I_ZEXT, 1'b0};
    localparam Form_t FM_BR2  = '{1'b1, 1'b1, W_NONE, I_SEXT, 1'b0};
    localparam Form_t FM_BR1  = '{1'b1, 1'b0, W_NONE, I_SEXT, 1'b0};
    localparam Form_t FM_BAL  = '{1'b1, 1'b0, W_RA,   I_SEXT, 1'b0};
    localparam Form_t FM_J    = '{1'b0, 1'b0, W_NONE, I_JIDX, 1'b0};
    localparam Form_t FM_JAL  = '{1'b0, 1'b0, W_RA,   I_JIDX, 1'b0};
    localparam Form_t FM_RR   = '{1'b1, 1'b1, W_RD,   I_ZERO, 1'b0};
    localparam Form_t FM_SH   = '{1'b0, 1'b1, W_RD,   I_SA,   1'b0};
    localparam Form_t FM_RS   = '{1'b1, 1'b0, W_NONE, I_ZERO, 1'b0};
    localparam Form_t FM_RSRD = '{1'b1, 1'b0, W_RD,   I_ZERO, 1'b0};
    localparam Form_t FM_RD   = '{1'b0, 1'b0, W_RD,   I_ZERO, 1'b0};
    localparam Form_t FM_RSRT = '{1'b1, 1'b1, W_NONE, I_ZERO, 1'b0};

endpackage

// File: rtl/id_decode_queue_inst_decode.sv
// id_inst_decode: pure combinational MIPS instruction decoder.
// Produces an Id_entry_t with pc left at zero for the caller to fill.
module id_inst_decode
    import id_decode_queue_pkg::*;
(
    input  Inst_t     inst_i,
    output Id_entry_t entry_o
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm16;
    logic [4:0]  wa;
    Oper_t       oper;
    Form_t       form;
    Id_entry_t   e;

    assign op    = inst_i[31:26];
    assign rs    = inst_i[25:21];
    assign rt    = inst_i[20:16];
    assign rd    = inst_i[15:11];
    assign sa    = inst_i[10:6];
    assign funct = inst_i[5:0];
    assign imm16 = inst_i[15:0];

    // Classify the instruction into an operation and an operand form
    always_comb begin
        oper = OP_NOP;
        form = FM_RSVD;
        unique case (op)
            OPC_SPECIAL: begin
                form = FM_RR;
                unique case (funct)
                    FN_SLL:   begin oper = OP_SLL;   form = FM_SH;   end
                    FN_SRL:   begin oper = OP_SRL;   form = FM_SH;   end
                    FN_SRA:   begin oper = OP_SRA;   form = FM_SH;   end
                    FN_SLLV:  oper = OP_SLLV;
                    FN_SRLV:  oper = OP_SRLV;
                    FN_SRAV:  oper = OP_SRAV;
                    FN_JR:    begin oper = OP_JR;    form = FM_RS;   end
                    FN_JALR:  begin oper = OP_JALR;  form = FM_RSRD; end
                    FN_MFHI:  begin oper = OP_MFHI;  form = FM_RD;   end
                    FN_MTHI:  begin oper = OP_MTHI;  form = FM_RS;   end
                    FN_MFLO:  begin oper = OP_MFLO;  form = FM_RD;   end
                    FN_MTLO:  begin oper = OP_MTLO;  form = FM_RS;   end
                    FN_MULT:  begin oper = OP_MULT;  form = FM_RSRT; end
                    FN_MULTU: begin oper = OP_MULTU; form = FM_RSRT; end
                    FN_ADD:   oper = OP_ADD;
                    FN_ADDU:  oper = OP_ADDU;
                    FN_SUB:   oper = OP_SUB;
                    FN_SUBU:  oper = OP_SUBU;
                    FN_AND:   oper = OP_AND;
                    FN_OR:    oper = OP_OR;
                    FN_XOR:   oper = OP_XOR;
                    FN_NOR:   oper = OP_NOR;
                    FN_SLT:   oper = OP_SLT;
                    FN_SLTU:  oper = OP_SLTU;
                    default:  form = FM_RSVD;
                endcase
            end
            OPC_REGIMM: begin
                unique case (rt)
                    RT_BLTZ:   begin oper = OP_BLTZ;   form = FM_BR1; end
                    RT_BGEZ:   begin oper = OP_BGEZ;   form = FM_BR1; end
                    RT_BLTZAL: begin oper = OP_BLTZAL; form = FM_BAL; end
                    RT_BGEZAL: begin oper = OP_BGEZAL; form = FM_BAL; end
                    default:   form = FM_RSVD;
                endcase
            end
            OPC_SPECIAL2: begin
                unique case (funct)
                    FN2_MUL: begin oper = OP_MUL; form = FM_RR;   end
                    FN2_CLZ: begin oper = OP_CLZ; form = FM_RSRD; end
                    FN2_CLO: begin oper = OP_CLO; form = FM_RSRD; end
                    default: form = FM_RSVD;
                endcase
            end
            OPC_J:     begin oper = OP_J;     form = FM_J;    end
            OPC_JAL:   begin oper = OP_JAL;   form = FM_JAL;  end
            OPC_BEQ:   begin oper = OP_BEQ;   form = FM_BR2;  end
            OPC_BNE:   begin oper = OP_BNE;   form = FM_BR2;  end
            OPC_BLEZ:  begin oper = OP_BLEZ;  form = FM_BR1;  end
            OPC_BGTZ:  begin oper = OP_BGTZ;  form = FM_BR1;  end
            OPC_ADDI:  begin oper = OP_ADDI;  form = FM_ARI;  end
            OPC_ADDIU: begin oper = OP_ADDIU; form = FM_ARI;  end
            OPC_SLTI:  begin oper = OP_SLTI;  form = FM_ARI;  end
            OPC_SLTIU: begin oper = OP_SLTIU; form = FM_ARI;  end
            OPC_ANDI:  begin oper = OP_ANDI;  form = FM_LOGI; end
            OPC_ORI:   begin oper = OP_ORI;   form = FM_LOGI; end
            OPC_XORI:  begin oper = OP_XORI;  form = FM_LOGI; end
            OPC_LUI:   begin oper = OP_LUI;   form = FM_LUI;  end
            OPC_LB:    begin oper = OP_LB;    form = FM_ARI;  end
            OPC_LH:    begin oper = OP_LH;    form = FM_ARI;  end
            OPC_LW:    begin oper = OP_LW;    form = FM_ARI;  end
            OPC_LBU:   begin oper = OP_LBU;   form = FM_ARI;  end
            OPC_LHU:   begin oper = OP_LHU;   form = FM_ARI;  end
            OPC_SB:    begin oper = OP_SB;    form = FM_BR2;  end
            OPC_SH:    begin oper = OP_SH;    form = FM_BR2;  end
            OPC_SW:    begin oper = OP_SW;    form = FM_BR2;  end
            default:   form = FM_RSVD;
        endcase
    end

    // Expand the operand form into register and immediate fields
    always_comb begin
        e = '0;
        e.oper = form.rsvd ? OP_NOP : oper;
        e.rsvd = form.rsvd;
        e.reg1_read = form.rd_rs;
        e.reg1_addr = form.rd_rs ? rs : 5'd0;
        e.reg2_read = form.rd_rt;
        e.reg2_addr = form.rd_rt ? rt : 5'd0;
        unique case (form.wsel)
            W_RT:    wa = rt;
            W_RD:    wa = rd;
            W_RA:    wa = REG_RA;
            default: wa = 5'd0;
        endcase
        e.wreg_addr  = wa;
        e.wreg_write = (form.wsel != W_NONE) && (wa != 5'd0);
        unique case (form.isel)
            I_ZEXT:  e.immediate = {16'b0, imm16};
            I_SEXT:  e.immediate = {{16{imm16[15]}}, imm16};
            I_SA:    e.immediate = {27'b0, sa};
            I_JIDX:  e.immediate = {6'b0, inst_i[25:0]};
            default: e.immediate = 32'd0;
        endcase
    end

    assign entry_o = e;

endmodule

// File: rtl/id_decode_queue.sv
// Decode queue: decodes fetched instructions into a DEPTH-deep FIFO.
// Optional same-cycle bypass when empty: define ID_QUEUE_BYPASS_EN.
module id_decode_queue
    import id_decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  Inst_t            in_inst,
    input  logic [31:0]      in_pc,
    input  logic             flush,
    input  logic             flush_keep_slot,
    output logic             out_valid,
    input  logic             out_ready,
    output Oper_t            out_oper,
    output logic             out_reg1_read,
    output logic             out_reg2_read,
    output logic [4:0]       out_reg1_addr,
    output logic [4:0]       out_reg2_addr,
    output logic             out_wreg_write,
    output logic [4:0]       out_wreg_addr,
    output logic [31:0]      out_immediate,
    output logic [31:0]      out_pc,
    output logic             out_rsvd,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    Id_entry_t        mem_q [DEPTH];
    Id_entry_t        dec_w;
    Id_entry_t        in_entry;
    Id_entry_t        head;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             byp;
    logic             enq;
    logic             deq;
    logic             keep;

    id_inst_decode u_dec (
        .inst_i  (in_inst),
        .entry_o (dec_w)
    );

    // Attach the fetch PC to the decoded fields
    always_comb begin
        in_entry    = dec_w;
        in_entry.pc = in_pc;
    end

`ifdef ID_QUEUE_BYPASS_EN
    assign byp = (count_q == '0) & in_valid & out_ready & ~flush;
`else
    assign byp = 1'b0;
`endif

    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = byp | (count_q != '0);
    assign deq       = out_ready & (count_q != '0);
    assign enq       = in_valid & in_ready & ~flush & ~byp;
    assign keep      = flush & flush_keep_slot & (count_q != '0) & ~deq;

    // Next pointers and occupancy; a flush drops everything but a kept head
    always_comb begin
        rptr_d = deq ? rptr_q + PTR_W'(1) : rptr_q;
        if (flush) begin
            wptr_d  = rptr_d + PTR_W'(keep);
            count_d = CNT_W'(keep);
        end else begin
            wptr_d  = enq ? wptr_q + PTR_W'(1) : wptr_q;
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Queue storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            if (enq) begin
                mem_q[wptr_q] <= in_entry;
            end
        end
    end

    assign head           = byp ? in_entry : mem_q[rptr_q];
    assign out_oper       = head.oper;
    assign out_reg1_read  = head.reg1_read;
    assign out_reg1_addr  = head.reg1_addr;
    assign out_reg2_read  = head.reg2_read;
    assign out_reg2_addr  = head.reg2_addr;
    assign out_wreg_write = head.wreg_write;
    assign out_wreg_addr  = head.wreg_addr;
    assign out_immediate  = head.immediate;
    assign out_pc         = head.pc;
    assign out_rsvd       = head.rsvd;
    assign count          = count_q;

endmodule

// File: tb/tb_id_decode_queue.sv
// Bench for id_decode_queue: directed cases plus random traffic
// against a queue-based reference model with its own decoder.
module tb_id_decode_queue;
    import id_decode_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    localparam logic [5:0] OPS [25] = '{
        6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
        6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
        6'h1c, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b};
    localparam logic [5:0] FNS [24] = '{
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
        6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h20, 6'h21,
        6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    localparam logic [5:0] F2S [3] = '{6'h02, 6'h20, 6'h21};
    localparam logic [4:0] RIS [4] = '{5'h00, 5'h01, 5'h10, 5'h11};

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [31:0]      in_pc;
    logic             flush;
    logic             flush_keep_slot;
    logic             out_valid;
    logic             out_ready;
    Oper_t            out_oper;
    logic             out_reg1_read;
    logic             out_reg2_read;
    logic [4:0]       out_reg1_addr;
    logic [4:0]       out_reg2_addr;
    logic             out_wreg_write;
    logic [4:0]       out_wreg_addr;
    logic [31:0]      out_immediate;
    logic [31:0]      out_pc;
    logic             out_rsvd;
    logic [CNT_W-1:0] count;

    int        n_checks = 0;
    int        n_fail = 0;
    Id_entry_t mq[$];
    logic [31:0] pc_ctr = 32'h1000;

    id_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_inst         (in_inst),
        .in_pc           (in_pc),
        .flush           (flush),
        .flush_keep_slot (flush_keep_slot),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_oper        (out_oper),
        .out_reg1_read   (out_reg1_read),
        .out_reg2_read   (out_reg2_read),
        .out_reg1_addr   (out_reg1_addr),
        .out_reg2_addr   (out_reg2_addr),
        .out_wreg_write  (out_wreg_write),
        .out_wreg_addr   (out_wreg_addr),
        .out_immediate   (out_immediate),
        .out_pc          (out_pc),
        .out_rsvd        (out_rsvd),
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decoder written straight from the instruction rules
    function automatic Id_entry_t ref_dec(input logic [31:0] w,
                                          input logic [31:0] pc);
        Id_entry_t e;
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd;
        logic [31:0] se, ze, imm;
        bit urs, urt, known;
        int dst;
        Oper_t o;
        op = w[31:26]; fn = w[5:0];
        rs = w[25:21]; rt = w[20:16]; rd = w[15:11];
        se = {{16{w[15]}}, w[15:0]};
        ze = {16'h0, w[15:0]};
        urs = 0; urt = 0; known = 1; dst = -1; imm = 0; o = OP_NOP;
        if (op == 6'h00) begin
            case (fn)
                6'h00: o = OP_SLL;   6'h02: o = OP_SRL;   6'h03: o = OP_SRA;
                6'h04: o = OP_SLLV;  6'h06: o = OP_SRLV;  6'h07: o = OP_SRAV;
                6'h08: o = OP_JR;    6'h09: o = OP_JALR;
                6'h10: o = OP_MFHI;  6'h11: o = OP_MTHI;
                6'h12: o = OP_MFLO;  6'h13: o = OP_MTLO;
                6'h18: o = OP_MULT;  6'h19: o = OP_MULTU;
                6'h20: o = OP_ADD;   6'h21: o = OP_ADDU;
                6'h22: o = OP_SUB;   6'h23: o = OP_SUBU;
                6'h24: o = OP_AND;   6'h25: o = OP_OR;
                6'h26: o = OP_XOR;   6'h27: o = OP_NOR;
                6'h2a: o = OP_SLT;   6'h2b: o = OP_SLTU;
                default: known = 0;
            endcase
            if (fn inside {6'h00, 6'h02, 6'h03}) begin
                urt = 1; dst = int'(rd); imm = {27'h0, w[10:6]};
            end else if (fn inside {6'h08, 6'h11, 6'h13}) begin
                urs = 1;
            end else if (fn == 6'h09) begin
                urs = 1; dst = int'(rd);
            end else if (fn inside {6'h10, 6'h12}) begin
                dst = int'(rd);
            end else if (fn inside {6'h18, 6'h19}) begin
                urs = 1; urt = 1;
            end else begin
                urs = 1; urt = 1; dst = int'(rd);
            end
        end else if (op == 6'h01) begin
            case (rt)
                5'h00: o = OP_BLTZ;    5'h01: o = OP_BGEZ;
                5'h10: o = OP_BLTZAL;  5'h11: o = OP_BGEZAL;
                default: known = 0;
            endcase
            urs = 1; imm = se;
            if (rt[4]) dst = 31;
        end else if (op == 6'h02 || op == 6'h03) begin
            o = (op == 6'h02) ? OP_J : OP_JAL;
            imm = {6'h0, w[25:0]};
            if (op == 6'h03) dst = 31;
        end else if (op inside {6'h04, 6'h05}) begin
            o = (op == 6'h04) ? OP_BEQ : OP_BNE;
            urs = 1; urt = 1; imm = se;
        end else if (op inside {6'h06, 6'h07}) begin
            o = (op == 6'h06) ? OP_BLEZ : OP_BGTZ;
            urs = 1; imm = se;
        end else if (op inside {[6'h08:6'h0b]}) begin
            case (op)
                6'h08: o = OP_ADDI;  6'h09: o = OP_ADDIU;
                6'h0a: o = OP_SLTI;  default: o = OP_SLTIU;
            endcase
            urs = 1; dst = int'(rt); imm = se;
        end else if (op inside {6'h0c, 6'h0d, 6'h0e}) begin
            case (op)
                6'h0c: o = OP_ANDI;  6'h0d: o = OP_ORI;
                default: o = OP_XORI;
            endcase
            urs = 1; dst = int'(rt); imm = ze;
        end else if (op == 6'h0f) begin
            o = OP_LUI; dst = int'(rt); imm = ze;
        end else if (op == 6'h1c) begin
            case (fn)
                6'h02: begin o = OP_MUL; urs = 1; urt = 1; dst = int'(rd); end
                6'h20: begin o = OP_CLZ; urs = 1; dst = int'(rd); end
                6'h21: begin o = OP_CLO; urs = 1; dst = int'(rd); end
                default: known = 0;
            endcase
        end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
            case (op)
                6'h20: o = OP_LB;  6'h21: o = OP_LH;  6'h23: o = OP_LW;
                6'h24: o = OP_LBU; default: o = OP_LHU;
            endcase
            urs = 1; dst = int'(rt); imm = se;
        end else if (op inside {6'h28, 6'h29, 6'h2b}) begin
            case (op)
                6'h28: o = OP_SB; 6'h29: o = OP_SH; default: o = OP_SW;
            endcase
            urs = 1; urt = 1; imm = se;
        end else begin
            known = 0;
        end
        e = '0;
        e.pc = pc;
        if (!known) begin
            e.rsvd = 1'b1;
            return e;
        end
        e.oper       = o;
        e.reg1_read  = urs;
        e.reg1_addr  = urs ? rs : 5'd0;
        e.reg2_read  = urt;
        e.reg2_addr  = urt ? rt : 5'd0;
        e.wreg_addr  = (dst < 0) ? 5'd0 : 5'(dst);
        e.wreg_write = (dst > 0);
        e.immediate  = imm;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) != 0) begin
            w[31:26] = OPS[$urandom_range(0, 24)];
            if ($urandom_range(0, 7) == 0) w[20:11] = 10'h0;
            if (w[31:26] == 6'h00) w[5:0] = FNS[$urandom_range(0, 23)];
            if (w[31:26] == 6'h1c) w[5:0] = F2S[$urandom_range(0, 2)];
            if (w[31:26] == 6'h01) w[20:16] = RIS[$urandom_range(0, 3)];
        end
        return w;
    endfunction

    // One cycle: drive at the falling edge, check, then advance the model
    task automatic step(input bit iv, input logic [31:0] w,
                        input logic [31:0] pc, input bit ordy,
                        input bit fl, input bit keep);
        Id_entry_t exp;
        bit byp;
        bit deq;
        int n;
        in_valid = iv; in_inst = w; in_pc = pc;
        out_ready = ordy; flush = fl; flush_keep_slot = keep;
        #1;
        n = mq.size();
        byp = 0;
`ifdef ID_QUEUE_BYPASS_EN
        byp = (n == 0) && iv && ordy && !fl;
`endif
        check("count", 64'(count), 64'(n));
        check("in_ready", 64'(in_ready), 64'(n < DEPTH));
        check("out_valid", 64'(out_valid), 64'((n != 0) || byp));
        if (n != 0 || byp) begin
            exp = byp ? ref_dec(w, pc) : mq[0];
            check("oper", 64'(out_oper), 64'(exp.oper));
            check("regs", 64'({out_reg1_read, out_reg1_addr, out_reg2_read,
                   out_reg2_addr, out_wreg_write, out_wreg_addr, out_rsvd}),
                  64'({exp.reg1_read, exp.reg1_addr, exp.reg2_read,
                   exp.reg2_addr, exp.wreg_write, exp.wreg_addr, exp.rsvd}));
            check("imm", 64'(out_immediate), 64'(exp.immediate));
            check("pc", 64'(out_pc), 64'(exp.pc));
        end
        deq = ordy && (n != 0);
        if (fl) begin
            if (keep && n != 0 && !deq) begin
                exp = mq[0];
                mq.delete();
                mq.push_back(exp);
            end else begin
                mq.delete();
            end
        end else begin
            if (deq) void'(mq.pop_front());
            if (iv && n < DEPTH && !byp) mq.push_back(ref_dec(w, pc));
        end
        @(negedge clk);
        in_valid = 0; out_ready = 0; flush = 0; flush_keep_slot = 0;
    endtask

    task automatic push(input logic [31:0] w);
        step(1, w, pc_ctr, 0, 0, 0);
        pc_ctr += 4;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) begin
            step(0, 32'h0, 32'h0, 1, 0, 0);
        end
        check("drained", 64'(count), 64'(0));
    endtask

    initial begin
        logic [31:0] head_pc;
        rst_n = 0; in_valid = 0; in_inst = 0; in_pc = 0;
        out_ready = 0; flush = 0; flush_keep_slot = 0;
        #2;
        check("rst_count", 64'(count), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_oper", 64'(out_oper), 64'(OP_NOP));
        check("rst_en", 64'({out_reg1_read, out_reg2_read, out_wreg_write,
              out_rsvd}), 64'(0));
        check("rst_imm", 64'(out_immediate), 64'(0));
        @(negedge clk);
        rst_n = 1;

        push(32'h34418000);
        #1;
        check("ori_oper", 64'(out_oper), 64'(OP_ORI));
        check("ori_regs", 64'({out_reg1_read, out_reg1_addr, out_reg2_read,
              out_wreg_write, out_wreg_addr}),
              64'({1'b1, 5'd2, 1'b0, 1'b1, 5'd1}));
        check("ori_imm", 64'(out_immediate), 64'h8000);
        drain();

        push(32'h2441FFFF);
        push(32'h0C000010);
        #1;
        check("addiu_imm", 64'(out_immediate), 64'hFFFFFFFF);
        step(0, 32'h0, 32'h0, 1, 0, 0);
        #1;
        check("jal_imm", 64'(out_immediate), 64'h10);
        check("jal_wb", 64'({out_wreg_write, out_wreg_addr}),
              64'({1'b1, 5'd31}));
        check("jal_rd", 64'({out_reg1_read, out_reg2_read}), 64'(0));
        drain();

        for (int i = 0; i < 5; i++) push(rand_inst());
        #1;
        check("full_count", 64'(count), 64'(DEPTH));
        check("full_ready", 64'(in_ready), 64'(0));
        drain();

        for (int i = 0; i < 3; i++) push(rand_inst());
        head_pc = mq[0].pc;
        step(0, 32'h0, 32'h0, 0, 1, 1);
        #1;
        check("keep_count", 64'(count), 64'(1));
        check("keep_pc", 64'(out_pc), 64'(head_pc));
        drain();
        for (int i = 0; i < 3; i++) push(rand_inst());
        step(1, rand_inst(), 32'hBEEF0, 1, 1, 1);
        #1;
        check("keep_deq_count", 64'(count), 64'(0));

        push(32'hFC000000);
        #1;
        check("rsvd_flag", 64'(out_rsvd), 64'(1));
        check("rsvd_oper", 64'(out_oper), 64'(OP_NOP));
        check("rsvd_en", 64'({out_reg1_read, out_reg2_read, out_wreg_write}),
              64'(0));
        drain();
        push(32'h00000020);
        #1;
        check("add0_wb", 64'(out_wreg_write), 64'(0));
        drain();

        push(rand_inst());
        push(rand_inst());
        #3;
        rst_n = 0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_count", 64'(count), 64'(0));
        check("mid_rst_oper", 64'(out_oper), 64'(OP_NOP));
        mq.delete();
        @(negedge clk);
        rst_n = 1;

`ifdef ID_QUEUE_BYPASS_EN
        in_valid = 1; in_inst = 32'h34418000; in_pc = 32'h4444;
        out_ready = 1;
        #1;
        check("byp_valid", 64'(out_valid), 64'(1));
        check("byp_pc", 64'(out_pc), 64'h4444);
        @(negedge clk);
        in_valid = 0; out_ready = 0;
        #1;
        check("byp_count", 64'(count), 64'(0));
        @(negedge clk);
`endif

        for (int i = 0; i < 600; i++) begin
            bit fl;
            fl = ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 9) < 7, rand_inst(), pc_ctr,
                 $urandom_range(0, 9) < 5, fl, $urandom_range(0, 1) == 1);
            pc_ctr += 4;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
